// File: rtl/param_cpu_core.sv
// param_cpu_core: multi-cycle parametrised CPU core, IDLE -> EXEC -> WB, with a manual register-load port.
// Build option CPU_SAT_EN: overflowing ADD/SUB write the signed saturation value instead of wrapping.
module param_cpu_core #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  input  logic [31:0]                  ins,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [$clog2(NUM_REGS)-1:0]  ld_addr,
  input  logic [DATA_W-1:0]            ld_data,
  output logic                         busy,
  output logic                         wb_valid,
  output logic [$clog2(NUM_REGS)-1:0]  wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  output logic                         ovf,
  input  logic                         ovf_clr,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int SH_W   = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t              state;
  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   rs_q, rt_q, rd_q;
  logic                ovf_cand;
  logic [DATA_W-1:0]   a, b, sum, diff, alu_res;
  logic                alu_ovf;
  logic                unused_ins;

  // Only the OP/RS/RT/RD fields of the instruction word carry meaning.
  assign unused_ins = ^ins;

  assign a         = rf[rs_q];
  assign b         = rf[rt_q];
  assign busy      = (state != IDLE);
  assign ld_ready  = (state == IDLE);
  assign ins_ready = (state == IDLE) && !ld_valid;

  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      3'd0: begin
        alu_res = sum;
        alu_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      3'd1: begin
        alu_res = diff;
        alu_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      3'd2: alu_res = a & b;
      3'd3: alu_res = a | b;
      3'd4: alu_res = a ^ b;
      3'd5: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd6: alu_res = a << b[SH_W-1:0];
      3'd7: alu_res = a >> b[SH_W-1:0];
    endcase
`ifdef CPU_SAT_EN
    // A signed overflow always has the sign of A, so A picks the saturation rail.
    if (alu_ovf) alu_res = a[DATA_W-1] ? SAT_MIN : SAT_MAX;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      ovf_cand <= 1'b0;
      ovf      <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (ovf_clr) ovf <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_valid) begin
            rf[ld_addr] <= ld_data;
          end else if (ins_valid) begin
            op_q  <= ins[28:26];
            rs_q  <= ins[21 +: REG_AW];
            rt_q  <= ins[16 +: REG_AW];
            rd_q  <= ins[11 +: REG_AW];
            state <= EXEC;
          end
        end
        EXEC: begin
          wb_valid <= 1'b1;
          wb_addr  <= rd_q;
          wb_data  <= alu_res;
          ovf_cand <= alu_ovf;
          state    <= WB;
        end
        WB: begin
          // Placed after the clear so a same-cycle overflow set takes precedence.
          rf[wb_addr] <= wb_data;
          if (ovf_cand) ovf <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[k*DATA_W +: DATA_W] = rf[k];
  end

endmodule
